// File: rtl/hella_cache_arbiter.sv
// Round-robin arbiter that merges several requesters onto one downstream cache
// port, tracks stage-1/stage-2 ownership for kill/nack, and routes responses by tag.
module hella_cache_arbiter #(
  parameter  int NUM_REQ       = 2,
  parameter  int NUM_ADDR_BITS = 40,
  parameter  int NUM_DATA_BITS = 64,
  parameter  int NUM_TAG_BITS  = 7,
  localparam int CID           = $clog2(NUM_REQ),
  localparam int CTAG          = NUM_TAG_BITS - CID
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               c_req_valid,
  output logic [NUM_REQ-1:0]               c_req_ready,
  input  logic [NUM_REQ*NUM_ADDR_BITS-1:0] c_req_addr,
  input  logic [NUM_REQ*CTAG-1:0]          c_req_tag,
  input  logic [NUM_REQ*5-1:0]             c_req_cmd,
  input  logic [NUM_REQ*3-1:0]             c_req_typ,
  input  logic [NUM_REQ*NUM_DATA_BITS-1:0] c_s1_data,
  input  logic [NUM_REQ*8-1:0]             c_s1_mask,
  input  logic [NUM_REQ-1:0]               c_s1_kill,
  output logic [NUM_REQ-1:0]               c_rsp_valid,
  output logic [NUM_REQ-1:0]               c_rsp_nack,
  output logic [CTAG-1:0]                  c_rsp_tag,
  output logic [2:0]                       c_rsp_typ,
  output logic [NUM_DATA_BITS-1:0]         c_rsp_data,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [NUM_ADDR_BITS-1:0]         req_addr,
  output logic [NUM_TAG_BITS-1:0]          req_tag,
  output logic [4:0]                       req_cmd,
  output logic [2:0]                       req_typ,
  output logic [NUM_DATA_BITS-1:0]         s1_data,
  output logic [7:0]                       s1_mask,
  output logic                             s1_kill,
  input  logic                             s2_nack,
  input  logic                             rsp_valid,
  input  logic [NUM_TAG_BITS-1:0]          rsp_tag,
  input  logic [2:0]                       rsp_typ,
  input  logic [NUM_DATA_BITS-1:0]         rsp_data,
  output logic                             busy,
  output logic                             rsp_err
);

  logic [CID-1:0]  rr_ptr, gnt, gnt_hi, gnt_lo, rr_next;
  logic            hi_found, fire;
  logic            s1_v, s2_v;
  logic [CID-1:0]  s1_id, s2_id;
  logic [CID-1:0]  rsp_id;
  logic [CTAG-1:0] gnt_tag;
  logic            bad_id;

  // Scanning downward means the lowest matching index wins: gnt_lo is the wrap
  // candidate, gnt_hi the first valid at or above rr_ptr.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    hi_found = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (c_req_valid[j]) begin
        gnt_lo = CID'(j);
        if (CID'(j) >= rr_ptr) begin
          gnt_hi   = CID'(j);
          hi_found = 1'b1;
        end
      end
    end
    gnt = hi_found ? gnt_hi : gnt_lo;
  end

  assign req_valid = |c_req_valid;
  assign fire      = req_valid & req_ready;
  assign rr_next   = (gnt == CID'(NUM_REQ - 1)) ? '0 : gnt + CID'(1);
  assign req_tag   = {gnt, gnt_tag};

  always_comb begin
    req_addr    = '0;
    gnt_tag     = '0;
    req_cmd     = '0;
    req_typ     = '0;
    c_req_ready = '0;
    s1_data     = '0;
    s1_mask     = '0;
    s1_kill     = 1'b0;
    c_rsp_nack  = '0;
    c_rsp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt == CID'(j)) begin
        req_addr       = c_req_addr[j*NUM_ADDR_BITS +: NUM_ADDR_BITS];
        gnt_tag        = c_req_tag[j*CTAG +: CTAG];
        req_cmd        = c_req_cmd[j*5 +: 5];
        req_typ        = c_req_typ[j*3 +: 3];
        c_req_ready[j] = req_ready;
      end
      // Stage-1 signals are zero when the stage is empty, including during reset.
      if (s1_v && s1_id == CID'(j)) begin
        s1_data = c_s1_data[j*NUM_DATA_BITS +: NUM_DATA_BITS];
        s1_mask = c_s1_mask[j*8 +: 8];
        s1_kill = c_s1_kill[j];
      end
      c_rsp_nack[j]  = s2_v & s2_nack & (s2_id == CID'(j));
      c_rsp_valid[j] = rsp_valid & (rsp_id == CID'(j));
    end
  end

  assign rsp_id     = rsp_tag[NUM_TAG_BITS-1:CTAG];
  assign bad_id     = rsp_valid & (rsp_id > CID'(NUM_REQ - 1));
  assign c_rsp_tag  = rsp_tag[CTAG-1:0];
  assign c_rsp_typ  = rsp_typ;
  assign c_rsp_data = rsp_data;
  assign busy       = s1_v | s2_v;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= '0;
      s1_v    <= 1'b0;
      s1_id   <= '0;
      s2_v    <= 1'b0;
      s2_id   <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (fire) begin
        rr_ptr <= rr_next;
        s1_id  <= gnt;
      end
      s1_v  <= fire;
      s2_v  <= s1_v & ~s1_kill;
      s2_id <= s1_id;
      if (bad_id) rsp_err <= 1'b1;
    end
  end

endmodule

// File: doc/hella_cache_arbiter.md
HELLA_CACHE_ARBITER -- requirements
Module: hella_cache_arbiter

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- NUM_REQ, 2, number of requesters; range 2..8.
- NUM_ADDR_BITS, 40, address width.
- NUM_DATA_BITS, 64, data width.
- NUM_TAG_BITS, 7, downstream tag width.
REQ-002 The module SHALL use these derived widths:
- CID = clog2(NUM_REQ).
- CTAG = NUM_TAG_BITS - CID.
REQ-003 The module SHALL have these ports (name, direction, width, meaning). Vectors marked x are packed per requester, requester 0 in the LSBs.
- clock, in, 1, single clock.
- reset_n, in, 1, asynchronous, active-low reset.
- c_req_valid / c_req_ready, in / out, NUM_REQ, requester request handshake.
- c_req_addr, in, NUM_REQ x NUM_ADDR_BITS, request address.
- c_req_tag, in, NUM_REQ x CTAG, request tag.
- c_req_cmd / c_req_typ, in, NUM_REQ x 5 / NUM_REQ x 3, command and type.
- c_s1_data / c_s1_mask / c_s1_kill, in, NUM_REQ x NUM_DATA_BITS / NUM_REQ x 8 / NUM_REQ, stage-1 data, mask and kill.
- c_rsp_valid / c_rsp_nack, out, NUM_REQ / NUM_REQ, per-requester response and nack strobes.
- c_rsp_tag / c_rsp_typ / c_rsp_data, out, CTAG / 3 / NUM_DATA_BITS, shared response fields.
- req_valid / req_ready, out / in, 1, downstream request handshake.
- req_addr / req_tag / req_cmd / req_typ, out, NUM_ADDR_BITS / NUM_TAG_BITS / 5 / 3, downstream request fields.
- s1_data / s1_mask / s1_kill, out, NUM_DATA_BITS / 8 / 1, downstream stage-1 signals.
- s2_nack, in, 1, downstream nack.
- rsp_valid / rsp_tag / rsp_typ / rsp_data, in, 1 / NUM_TAG_BITS / 3 / NUM_DATA_BITS, downstream response.
- busy, out, 1, stage 1 or stage 2 occupied.
- rsp_err, out, 1, sticky bad-tag flag.

Function
REQ-004 Arbitration SHALL be round-robin: the grant g is the first requester with c_req_valid set, searching upward from rr_ptr and wrapping modulo NUM_REQ.
REQ-005 req_valid SHALL equal the OR of c_req_valid, combinationally; the request path has zero cycles of latency.
REQ-006 req_addr, req_cmd and req_typ SHALL be requester g's fields; req_tag SHALL be {g[CID-1:0], c_req_tag[g]}.
REQ-007 c_req_ready[g] SHALL equal req_ready; every other bit of c_req_ready SHALL be 0.
REQ-008 A fire is req_valid and req_ready both high. On a fire, rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold, even if the grant changes.
REQ-009 Stage-1 registers: s1_v SHALL be set on the cycle after a fire and cleared otherwise; s1_id SHALL capture g on the fire.
REQ-010 While s1_v=1, s1_data, s1_mask and s1_kill SHALL be requester s1_id's values. While s1_v=0, these outputs SHALL be 0.
REQ-011 Stage-2 registers: s2_v SHALL be set to s1_v AND NOT s1_kill on the next cycle; s2_id SHALL capture s1_id.
REQ-012 c_rsp_nack[s2_id] SHALL equal s2_nack AND s2_v; all other bits SHALL be 0.
REQ-013 An s2_nack received while s2_v=0 SHALL be ignored.
REQ-014 Response routing: with id = rsp_tag[NUM_TAG_BITS-1:CTAG] and id < NUM_REQ, c_rsp_valid[id] SHALL equal rsp_valid, combinationally.
REQ-015 c_rsp_tag SHALL be rsp_tag[CTAG-1:0]; c_rsp_typ and c_rsp_data SHALL pass through unregistered.
REQ-016 A response with rsp_valid=1 and id >= NUM_REQ SHALL be dropped (no c_rsp_valid bit set) and SHALL set rsp_err, which stays set until reset.
REQ-017 Back-to-back fires on consecutive cycles SHALL be supported: stage 1 and stage 2 each hold their own owner simultaneously.
REQ-018 busy SHALL equal s1_v OR s2_v.
REQ-019 A response and a nack in the same cycle SHALL each be routed independently, including when both target the same requester.

Reset
REQ-020 While reset_n=0, the following SHALL be cleared asynchronously: rr_ptr=0, s1_v=0, s2_v=0, s1_id=0, s2_id=0, rsp_err=0.
REQ-021 During reset, s1_data, s1_mask, s1_kill, c_rsp_nack and busy SHALL read 0.
REQ-022 During reset, req_valid and c_req_ready SHALL still follow the inputs combinationally.
REQ-023 A reset asserted mid-transaction SHALL discard the in-flight stage-1 and stage-2 owners; a nack arriving after reset deassertion SHALL be ignored.
REQ-024 Reset deassertion SHALL be synchronised to clock by the instantiating level, not inside this block.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Scenario 1: NUM_REQ=2, both c_req_valid=1, req_ready=1 for 4 cycles -> grants 0,1,0,1; req_tag[6] toggles 0,1,0,1.
- Scenario 2: requester 1 fires with c_req_tag=0x15, then rsp_valid=1 with rsp_tag=0x55 -> c_rsp_valid=2'b10 and c_rsp_tag=0x15.
- Scenario 3: requester 0 fires; in the next cycle c_s1_kill[0]=1; in the following cycle s2_nack=1 -> s1_kill=1 and c_rsp_nack=0.
- Scenario 4: requester 0 fires, then requester 1 fires the next cycle; nack asserted on 2 consecutive cycles -> c_rsp_nack=01 then 10.
- Scenario 5: NUM_REQ=3, rsp_valid=1 with tag id=3 -> all c_rsp_valid bits 0 and rsp_err=1 from the next cycle.
- Scenario 6: reset_n pulled low while s1_v=1 -> busy=0 immediately; s1_data=0.
